signed_to_unsigned_conv: RTL and testbench

//   Converts a stream of two's-complement signed samples into unsigned samples.
//   It is the return path for the unsigned->signed converter.
//   - Two conversion modes: clamp (negatives clamp to zero) and offset-binary (adds 2^(W-1)).
//   - Two-stage registered pipeline with valid/ready on both sides.
//   - Sticky saturating counter of clamped beats.

---
 rtl/signed_to_unsigned_conv_if.sv | 27 ++
 rtl/signed_to_unsigned_conv.sv | 108 ++++++++++
 tb/tb_signed_to_unsigned_conv.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/signed_to_unsigned_conv_if.sv
// rtl/signed_to_unsigned_conv_if.sv - stream and status bundle for the signed-to-unsigned converter
interface signed_to_unsigned_conv_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_clamped;
    logic [CNT_W-1:0] clamp_count;

    // Upstream source / downstream sink side
    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_clamped, clamp_count
    );

    // Converter side
    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_clamped, clamp_count
    );
endinterface

// File: rtl/signed_to_unsigned_conv.sv
// rtl/signed_to_unsigned_conv.sv - two-stage signed-to-unsigned converter with clamp counter
module signed_to_unsigned_conv #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    signed_to_unsigned_conv_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Stage 1: raw sample plus the mode it arrived with
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_data_q,  s1_data_d;
    logic             s1_mode_q,  s1_mode_d;

    // Stage 2: converted result, drives the output side directly
    logic             s2_valid_q,   s2_valid_d;
    logic [WIDTH-1:0] s2_data_q,    s2_data_d;
    logic             s2_clamped_q, s2_clamped_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             adv;
    logic             in_fire;
    logic             out_fire;
    logic [WIDTH-1:0] conv_data;
    logic             conv_clamped;

    // Handshake decode; in_ready looks through to out_ready so a full pipe keeps streaming
    always_comb begin
        adv      = !s2_valid_q || bus.out_ready;
        in_fire  = bus.in_valid && (!s1_valid_q || adv);
        out_fire = s2_valid_q && bus.out_ready;
    end

    // Conversion of the S1 sample: clamp negatives to zero, or flip the msb for offset-binary
    always_comb begin
        conv_data    = s1_data_q;
        conv_clamped = 1'b0;
        if (s1_mode_q) begin
            conv_data[WIDTH-1] = ~s1_data_q[WIDTH-1];
        end else if (s1_data_q[WIDTH-1]) begin
            conv_data    = '0;
            conv_clamped = 1'b1;
        end
    end

    // Next-state for both stages and the saturating clamp counter
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_data_d    = s1_data_q;
        s1_mode_d    = s1_mode_q;
        s2_valid_d   = s2_valid_q;
        s2_data_d    = s2_data_q;
        s2_clamped_d = s2_clamped_q;
        cnt_d        = cnt_q;

        if (adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d    = conv_data;
                s2_clamped_d = conv_clamped;
            end
            s1_valid_d = 1'b0;
        end

        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_data_d  = bus.in_data;
            s1_mode_d  = bus.in_mode;
        end

        if (out_fire && s2_clamped_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers; reset drops anything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            s1_mode_q    <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_data_q    <= '0;
            s2_clamped_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            s1_mode_q    <= s1_mode_d;
            s2_valid_q   <= s2_valid_d;
            s2_data_q    <= s2_data_d;
            s2_clamped_q <= s2_clamped_d;
            cnt_q        <= cnt_d;
        end
    end

    // Output drive
    always_comb begin
        bus.in_ready    = !s1_valid_q || adv;
        bus.out_valid   = s2_valid_q;
        bus.out_data    = s2_data_q;
        bus.out_clamped = s2_clamped_q;
        bus.clamp_count = cnt_q;
    end
endmodule

// File: tb/tb_signed_to_unsigned_conv.sv
// tb/tb_signed_to_unsigned_conv.sv - scoreboard bench for signed_to_unsigned_conv
module tb_signed_to_unsigned_conv;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    signed_to_unsigned_conv_if #(.WIDTH(4), .CNT_W(8)) bus_a ();
    signed_to_unsigned_conv_if #(.WIDTH(4), .CNT_W(2)) bus_b ();

    signed_to_unsigned_conv #(.WIDTH(4), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    signed_to_unsigned_conv #(.WIDTH(4), .CNT_W(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    logic [4:0] q_a[$];
    logic [4:0] q_b[$];
    int exp_cnt_a;
    int exp_cnt_b;
    int checks;
    int failures;

    function automatic logic [4:0] model(input logic [3:0] d, input logic m);
        int v;
        int u;
        v = int'($signed(d));
        if (m) begin
            u = v + 8;
            return {u[3:0], 1'b0};
        end
        if (v < 0) return {4'd0, 1'b1};
        return {d, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic       a_in, a_out, b_in, b_out, r;
        logic [4:0] e;
        @(negedge clk);
        r     = rst;
        a_in  = bus_a.in_valid && bus_a.in_ready;
        a_out = bus_a.out_valid && bus_a.out_ready;
        b_in  = bus_b.in_valid && bus_b.in_ready;
        b_out = bus_b.out_valid && bus_b.out_ready;
        if (!r) begin
            if (a_out) begin
                if (q_a.size() == 0) check("a_unexpected_beat", 1, 0);
                else begin
                    e = q_a.pop_front();
                    check("a_out_data", 32'(bus_a.out_data), 32'(e[4:1]));
                    check("a_out_clamped", 32'(bus_a.out_clamped), 32'(e[0]));
                    if (e[0] && exp_cnt_a < 255) exp_cnt_a++;
                end
            end
            if (a_in) q_a.push_back(model(bus_a.in_data, bus_a.in_mode));
            if (b_out) begin
                if (q_b.size() == 0) check("b_unexpected_beat", 1, 0);
                else begin
                    e = q_b.pop_front();
                    check("b_out_data", 32'(bus_b.out_data), 32'(e[4:1]));
                    check("b_out_clamped", 32'(bus_b.out_clamped), 32'(e[0]));
                    if (e[0] && exp_cnt_b < 3) exp_cnt_b++;
                end
            end
            if (b_in) q_b.push_back(model(bus_b.in_data, bus_b.in_mode));
        end
        @(posedge clk);
        #1;
        if (r) begin
            q_a.delete();
            q_b.delete();
            exp_cnt_a = 0;
            exp_cnt_b = 0;
        end
        check("a_clamp_count", 32'(bus_a.clamp_count), 32'(exp_cnt_a));
        check("b_clamp_count", 32'(bus_b.clamp_count), 32'(exp_cnt_b));
    endtask

    logic [3:0] vals[3];
    int idx;
    int bound;

    initial begin
        checks = 0;
        failures = 0;
        exp_cnt_a = 0;
        exp_cnt_b = 0;
        bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_mode = 1'b0; bus_a.out_ready = 1'b1;
        bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.in_mode = 1'b0; bus_b.out_ready = 1'b1;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", 32'(bus_a.out_valid), 0);
        check("rst_in_ready", 32'(bus_a.in_ready), 1);
        check("rst_out_data", 32'(bus_a.out_data), 0);
        check("rst_out_clamped", 32'(bus_a.out_clamped), 0);
        check("rst_count", 32'(bus_a.clamp_count), 0);

        // 1: positive sample in clamp mode, two-cycle latency
        bus_a.in_valid = 1'b1; bus_a.in_data = 4'b0101; bus_a.in_mode = 1'b0;
        step();
        bus_a.in_valid = 1'b0;
        check("t1_lat_cycle1", 32'(bus_a.out_valid), 0);
        step();
        check("t1_lat_cycle2", 32'(bus_a.out_valid), 1);
        check("t1_data", 32'(bus_a.out_data), 32'h5);
        step();

        // 2: negatives clamp to zero and count
        bus_a.in_valid = 1'b1; bus_a.in_data = 4'b1111;
        step();
        bus_a.in_data = 4'b1000;
        step();
        bus_a.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("t2_count", 32'(bus_a.clamp_count), 2);

        // 3: offset-binary, back-to-back
        bus_a.in_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_a.in_valid = 1'b1;
            case (i)
                0: bus_a.in_data = 4'b1000;
                1: bus_a.in_data = 4'b1111;
                2: bus_a.in_data = 4'b0000;
                default: bus_a.in_data = 4'b0111;
            endcase
            step();
            if (i >= 1) check("t3_stream_valid", 32'(bus_a.out_valid), 1);
        end
        bus_a.in_valid = 1'b0;
        step();
        check("t3_last_valid", 32'(bus_a.out_valid), 1);
        check("t3_last_data", 32'(bus_a.out_data), 32'hf);
        step();
        check("t3_drained", 32'(bus_a.out_valid), 0);

        // 4: backpressure with three beats offered
        bus_a.in_mode = 1'b0;
        vals[0] = 4'd1; vals[1] = 4'd2; vals[2] = 4'd3;
        bus_a.out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            bus_a.in_valid = (idx < 3);
            bus_a.in_data = vals[idx < 3 ? idx : 2];
            if (bus_a.in_valid && bus_a.in_ready) idx++;
            step();
            if (c >= 1) check("t4_hold_data", 32'(bus_a.out_data), 32'h1);
        end
        check("t4_accepted", 32'(idx), 2);
        check("t4_in_ready_low", 32'(bus_a.in_ready), 0);
        check("t4_out_valid_held", 32'(bus_a.out_valid), 1);
        bus_a.out_ready = 1'b1;
        bound = 0;
        while (idx < 3 && bound < 10) begin
            bus_a.in_data = vals[idx];
            if (bus_a.in_valid && bus_a.in_ready) idx++;
            step();
            bound++;
        end
        check("t4_third_accepted", 32'(idx), 3);
        bus_a.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("t4_all_delivered", 32'(q_a.size()), 0);

        // 5: narrow counter saturates
        bus_b.in_mode = 1'b0;
        bus_b.in_data = 4'b1111;
        bus_b.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) step();
        bus_b.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("t5_sat_count", 32'(bus_b.clamp_count), 3);
        check("t5_all_delivered", 32'(q_b.size()), 0);

        // 6: reset with two beats in flight
        bus_a.in_mode = 1'b0;
        bus_a.in_valid = 1'b1; bus_a.in_data = 4'b1110;
        step();
        bus_a.in_data = 4'b0011;
        step();
        bus_a.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_out_valid", 32'(bus_a.out_valid), 0);
        check("t6_count", 32'(bus_a.clamp_count), 0);
        check("t6_in_ready", 32'(bus_a.in_ready), 1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t6_no_stale", 32'(bus_a.out_valid), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
